// File: rtl/axi4_lite_pixel_reader.sv
// AXI4-lite read initiator: fetches a frame one beat at a time and unpacks each
// returned word LSB-first into a valid/ready byte stream.
module axi4_lite_pixel_reader #(
  parameter int         LEN_W          = 20,
  parameter int         BYTES_PER_BEAT = 4,
  parameter bit         FIXED_ADDR     = 1'b0,
  parameter logic [2:0] ARPROT         = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] beat_count,
  output logic             busy,
  output logic             done,
  output logic             m_axi_arvalid,
  input  logic             m_axi_arready,
  output logic [31:0]      m_axi_araddr,
  output logic [2:0]       m_axi_arprot,
  input  logic             m_axi_rvalid,
  output logic             m_axi_rready,
  input  logic [31:0]      m_axi_rdata,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [7:0]       pix_data,
  output logic             pix_last
);

  typedef enum logic [1:0] {AR_IDLE, AR_WAIT, R_WAIT} ar_state_t;

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_BEAT - 1);

  ar_state_t        state_q, state_d;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] remaining_q;
  logic             busy_q, done_q;
  logic [31:0]      word_p0;
  logic [1:0]       idx_p0;
  logic             vld_p0;
  logic             last_beat_p0;
  logic             start_ok, ar_fire, r_fire, pix_fire, last_byte;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^base_addr[1:0];

  assign start_ok  = start && !busy_q;
  assign last_byte = (idx_p0 == LAST_IDX);
  assign pix_fire  = vld_p0 && pix_ready;
  assign ar_fire   = m_axi_arvalid && m_axi_arready;
  assign r_fire    = m_axi_rvalid && m_axi_rready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= AR_IDLE;
    else       state_q <= state_d;
  end

  // AR_IDLE raises arvalid straight from registered state so the first address
  // appears the cycle after start and back-to-back beats need no idle bubble.
  always_comb begin
    state_d       = state_q;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (state_q)
      AR_IDLE: begin
        if (busy_q && (remaining_q != '0)) begin
          m_axi_arvalid = 1'b1;
          state_d       = m_axi_arready ? R_WAIT : AR_WAIT;
        end
      end
      AR_WAIT: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = R_WAIT;
      end
      R_WAIT: begin
        m_axi_rready = !vld_p0 || (last_byte && pix_fire);
        if (m_axi_rvalid && m_axi_rready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        if (beat_count == '0) begin
          done_q <= 1'b1;
        end else begin
          busy_q      <= 1'b1;
          addr_q      <= {base_addr[31:2], 2'b00};
          remaining_q <= beat_count;
        end
      end
      if (ar_fire) begin
        remaining_q <= remaining_q - LEN_W'(1);
        if (!FIXED_ADDR) addr_q <= addr_q + 32'd4;
      end
      if (pix_fire && last_byte && last_beat_p0) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  // ---- stage p0: word buffer and byte unpack ----
  // A refill on the same edge as the final-byte handshake overrides the free.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_p0      <= '0;
      idx_p0       <= '0;
      vld_p0       <= 1'b0;
      last_beat_p0 <= 1'b0;
    end else if (r_fire) begin
      word_p0      <= m_axi_rdata;
      idx_p0       <= '0;
      vld_p0       <= 1'b1;
      last_beat_p0 <= (remaining_q == '0);
    end else if (pix_fire) begin
      if (last_byte) begin
        vld_p0 <= 1'b0;
        idx_p0 <= '0;
      end else begin
        idx_p0 <= idx_p0 + 2'd1;
      end
    end
  end

  assign pix_valid    = vld_p0;
  assign pix_data     = word_p0[{idx_p0, 3'b000} +: 8];
  assign pix_last     = vld_p0 && last_byte && last_beat_p0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_arprot = ARPROT;

endmodule

// File: tb/tb_axi4_lite_pixel_reader.sv
// Scoreboard bench: a word-mode reader on a memory model and a fixed-address
// byte-mode reader on a sequenced peripheral model, both checked by monitors.
module tb_axi4_lite_pixel_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } pix_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_extra(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endtask

  function automatic logic [31:0] mem_a(input logic [31:0] addr);
    case (addr)
      32'h0000_0100: mem_a = 32'h4433_2211;
      32'h0000_0104: mem_a = 32'h8877_6655;
      default:       mem_a = addr ^ 32'hA5C3_5A3C;
    endcase
  endfunction

  // ---------------- instance A: word reads, incrementing ----------------
  logic        a_start;
  logic [31:0] a_base;
  logic [19:0] a_count;
  logic        a_busy, a_done, a_arvalid, a_arready, a_rvalid, a_rready;
  logic [31:0] a_araddr, a_rdata;
  logic [2:0]  a_arprot;
  logic        a_pv, a_pr, a_pl;
  logic [7:0]  a_pd;
  int          pr_mode = 0;
  int unsigned stall_until = 0;

  assign a_pr      = (pr_mode == 0) ? 1'b1 : (pr_mode == 1) ? cyc[0] : 1'b0;
  assign a_arready = (cyc >= stall_until);

  axi4_lite_pixel_reader #(
    .LEN_W(20), .BYTES_PER_BEAT(4), .FIXED_ADDR(1'b0), .ARPROT(3'b000)
  ) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .base_addr(a_base), .beat_count(a_count),
    .busy(a_busy), .done(a_done),
    .m_axi_arvalid(a_arvalid), .m_axi_arready(a_arready), .m_axi_araddr(a_araddr),
    .m_axi_arprot(a_arprot), .m_axi_rvalid(a_rvalid), .m_axi_rready(a_rready),
    .m_axi_rdata(a_rdata), .pix_valid(a_pv), .pix_ready(a_pr), .pix_data(a_pd),
    .pix_last(a_pl)
  );

  always @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
    end else begin
      if (a_rvalid && a_rready) a_rvalid <= 1'b0;
      if (a_arvalid && a_arready) begin
        a_rvalid <= 1'b1;
        a_rdata  <= mem_a(a_araddr);
      end
    end
  end

  logic [31:0] exp_ar_a[$];
  pix_t        exp_pix_a[$];
  int          done_cnt_a = 0, ar_cnt_a = 0, pix_cnt_a = 0, pos_a = 0;

  initial begin
    logic        prev_ar_stall, prev_pix_stall, prev_pl;
    logic [31:0] prev_araddr, ea;
    logic [7:0]  prev_pd;
    pix_t        ep;
    prev_ar_stall = 1'b0; prev_pix_stall = 1'b0; prev_pl = 1'b0;
    prev_araddr = '0; prev_pd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ar_stall = 1'b0;
        prev_pix_stall = 1'b0;
        pos_a = 0;
      end else begin
        if (prev_ar_stall) begin
          check("ar_hold_valid", 32'(a_arvalid), 32'd1);
          check("ar_hold_addr", a_araddr, prev_araddr);
        end
        if (prev_pix_stall) begin
          check("pix_hold_valid", 32'(a_pv), 32'd1);
          check("pix_hold_data", 32'({a_pl, a_pd}), 32'({prev_pl, prev_pd}));
        end
        if (a_pv) check("rready_gate", 32'(a_rready && !(pos_a == 3 && a_pr)), 32'd0);
        if (a_arvalid && a_arready) begin
          ar_cnt_a++;
          if (exp_ar_a.size() == 0) fail_extra("araddr_extra", a_araddr);
          else begin
            ea = exp_ar_a.pop_front();
            check("araddr", a_araddr, ea);
          end
        end
        if (a_pv && a_pr) begin
          pix_cnt_a++;
          pos_a = (pos_a + 1) % 4;
          if (exp_pix_a.size() == 0) fail_extra("pix_extra", 32'({a_pl, a_pd}));
          else begin
            ep = exp_pix_a.pop_front();
            check("pix_last_data", 32'({a_pl, a_pd}), 32'({ep.last, ep.data}));
          end
        end
        if (a_done) begin
          done_cnt_a++;
          check("done_busy_low", 32'(a_busy), 32'd0);
        end
        prev_ar_stall  = a_arvalid && !a_arready;
        prev_araddr    = a_araddr;
        prev_pix_stall = a_pv && !a_pr;
        prev_pd        = a_pd;
        prev_pl        = a_pl;
      end
    end
  end

  // ---------------- instance B: fixed-address byte port ----------------
  logic        b_start;
  logic [31:0] b_base;
  logic [19:0] b_count;
  logic        b_busy, b_done, b_arvalid, b_arready, b_rvalid, b_rready;
  logic [31:0] b_araddr, b_rdata;
  logic [2:0]  b_arprot;
  logic        b_pv, b_pr, b_pl;
  logic [7:0]  b_pd;
  int          b_seq;

  assign b_arready = 1'b1;
  assign b_pr      = 1'b1;

  axi4_lite_pixel_reader #(
    .LEN_W(20), .BYTES_PER_BEAT(1), .FIXED_ADDR(1'b1), .ARPROT(3'b010)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .base_addr(b_base), .beat_count(b_count),
    .busy(b_busy), .done(b_done),
    .m_axi_arvalid(b_arvalid), .m_axi_arready(b_arready), .m_axi_araddr(b_araddr),
    .m_axi_arprot(b_arprot), .m_axi_rvalid(b_rvalid), .m_axi_rready(b_rready),
    .m_axi_rdata(b_rdata), .pix_valid(b_pv), .pix_ready(b_pr), .pix_data(b_pd),
    .pix_last(b_pl)
  );

  always @(posedge clk) begin
    if (reset) begin
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_seq    <= 0;
    end else begin
      if (b_rvalid && b_rready) b_rvalid <= 1'b0;
      if (b_arvalid && b_arready) begin
        b_rvalid <= 1'b1;
        b_rdata  <= {24'hDEADBE, 8'h0A + 8'(b_seq)};
        b_seq    <= b_seq + 1;
      end
    end
  end

  logic [31:0] exp_ar_b[$];
  pix_t        exp_pix_b[$];
  int          done_cnt_b = 0;

  initial begin
    logic [31:0] ea;
    pix_t        ep;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (b_arvalid && b_arready) begin
          if (exp_ar_b.size() == 0) fail_extra("b_araddr_extra", b_araddr);
          else begin
            ea = exp_ar_b.pop_front();
            check("b_araddr", b_araddr, ea);
          end
        end
        if (b_pv && b_pr) begin
          if (exp_pix_b.size() == 0) fail_extra("b_pix_extra", 32'({b_pl, b_pd}));
          else begin
            ep = exp_pix_b.pop_front();
            check("b_pix_last_data", 32'({b_pl, b_pd}), 32'({ep.last, ep.data}));
          end
        end
        if (b_done) done_cnt_b++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_frame_a(input logic [31:0] base, input int count);
    logic [31:0] addr, w;
    addr = base;
    for (int i = 0; i < count; i++) begin
      exp_ar_a.push_back(addr);
      w = mem_a(addr);
      for (int b = 0; b < 4; b++)
        exp_pix_a.push_back(pix_t'{data: w[8*b +: 8], last: (i == count - 1 && b == 3)});
      addr = addr + 32'd4;
    end
  endtask

  task automatic pulse_a(input logic [31:0] base, input int count);
    a_base  = base;
    a_count = count[19:0];
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input string name, input int start_cnt);
    int t;
    t = 0;
    while (done_cnt_a == start_cnt && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, "_done_seen"}, 32'(done_cnt_a != start_cnt), 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    check({name, "_done_once"}, done_cnt_a - start_cnt, 32'd1);
    check({name, "_pix_left"}, exp_pix_a.size(), 32'd0);
    check({name, "_ar_left"}, exp_ar_a.size(), 32'd0);
  endtask

  task automatic check_idle_a(input string name);
    check({name, "_busy"}, 32'(a_busy), 32'd0);
    check({name, "_done"}, 32'(a_done), 32'd0);
    check({name, "_arvalid"}, 32'(a_arvalid), 32'd0);
    check({name, "_rready"}, 32'(a_rready), 32'd0);
    check({name, "_pix_valid"}, 32'(a_pv), 32'd0);
    check({name, "_pix_last"}, 32'(a_pl), 32'd0);
    check({name, "_araddr"}, a_araddr, 32'd0);
    check({name, "_pix_data"}, 32'(a_pd), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, arc, n0, t;
    reset = 1'b1;
    a_start = 1'b0; a_base = '0; a_count = '0;
    b_start = 1'b0; b_base = '0; b_count = '0;
    repeat (3) @(posedge clk); #1;
    check_idle_a("rst");
    check("rst_arprot", 32'(a_arprot), 32'd0);
    check("rst_b_arvalid", 32'(b_arvalid), 32'd0);
    check("rst_b_pix_valid", 32'(b_pv), 32'd0);
    check("b_arprot", 32'(b_arprot), 32'd2);
    reset = 1'b0;
    @(posedge clk); #1;

    // word frame
    d = done_cnt_a;
    expect_frame_a(32'h0000_0100, 2);
    pulse_a(32'h0000_0100, 2);
    check("t1_busy", 32'(a_busy), 32'd1);
    check("t1_arvalid_latency", 32'(a_arvalid), 32'd1);
    check("t1_araddr_first", a_araddr, 32'h0000_0100);
    wait_done_a("t1", d);

    // AR stall and toggling backpressure
    pr_mode = 1;
    stall_until = cyc + 6;
    d = done_cnt_a;
    expect_frame_a(32'h0000_0140, 3);
    pulse_a(32'h0000_0140, 3);
    wait_done_a("t2", d);
    pr_mode = 0;

    // zero count
    arc = ar_cnt_a;
    pulse_a(32'h0000_0500, 0);
    check("t3_done", 32'(a_done), 32'd1);
    check("t3_busy", 32'(a_busy), 32'd0);
    check("t3_arvalid", 32'(a_arvalid), 32'd0);
    @(posedge clk); #1;
    check("t3_done_width", 32'(a_done), 32'd0);
    check("t3_no_ar", ar_cnt_a - arc, 32'd0);

    // start while busy is ignored; low address bits are dropped
    d = done_cnt_a;
    expect_frame_a(32'h0000_0300, 2);
    pulse_a(32'h0000_0303, 2);
    @(posedge clk); #1;
    pulse_a(32'h0000_0400, 5);
    wait_done_a("t4", d);
    repeat (10) begin @(posedge clk); #1; end
    check("t4_idle_arvalid", 32'(a_arvalid), 32'd0);

    // reset after three bytes of a four-beat frame
    expect_frame_a(32'h0000_0600, 4);
    n0 = pix_cnt_a;
    pulse_a(32'h0000_0600, 4);
    t = 0;
    while (pix_cnt_a - n0 < 3 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("t5_three_bytes", pix_cnt_a - n0, 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_a("t5_rst");
    exp_pix_a.delete();
    exp_ar_a.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    d = done_cnt_a;
    expect_frame_a(32'h0000_0700, 2);
    pulse_a(32'h0000_0700, 2);
    wait_done_a("t5", d);

    // address wrap
    d = done_cnt_a;
    exp_ar_a.push_back(32'hFFFF_FFFC);
    exp_ar_a.push_back(32'h0000_0000);
    for (int b = 0; b < 4; b++)
      exp_pix_a.push_back(pix_t'{data: 8'(32'h5A3C_A5C0 >> (8*b)), last: 1'b0});
    for (int b = 0; b < 4; b++)
      exp_pix_a.push_back(pix_t'{data: 8'(32'hA5C3_5A3C >> (8*b)), last: (b == 3)});
    pulse_a(32'hFFFF_FFFC, 2);
    wait_done_a("t6", d);

    // fixed-address byte port
    for (int i = 0; i < 3; i++) exp_ar_b.push_back(32'h3000_0010);
    exp_pix_b.push_back(pix_t'{data: 8'h0A, last: 1'b0});
    exp_pix_b.push_back(pix_t'{data: 8'h0B, last: 1'b0});
    exp_pix_b.push_back(pix_t'{data: 8'h0C, last: 1'b1});
    b_base  = 32'h3000_0010;
    b_count = 20'd3;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    check("t7_busy", 32'(b_busy), 32'd1);
    t = 0;
    while (done_cnt_b == 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check("t7_done_once", done_cnt_b, 32'd1);
    check("t7_pix_left", exp_pix_b.size(), 32'd0);
    check("t7_ar_left", exp_ar_b.size(), 32'd0);
    check("t7_busy_end", 32'(b_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
